// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly issue sequencer for an in-place radix-2 FFT: walks FFT_N stages of N/2
// butterflies, inserting a fixed drain gap after each stage, with all outputs registered.
module fft_stage_sequencer #(
  parameter int FFT_N     = 10,
  parameter int STAGE_GAP = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      hold,
  output logic                      busy,
  output logic                      done,
  output logic                      oact,
  output logic [1:0]                octrl,
  output logic [FFT_N-2:0]          oMemAddr,
  output logic [FFT_N-2:0]          oTwAddr,
  output logic [$clog2(FFT_N)-1:0]  oStage
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | issuing butterflies of stage s (hold stalls issue)
  // GAP   | STAGE_GAP idle cycles for write-back drain
  // DONE  | one-cycle completion pulse

  localparam int KW = FFT_N - 1;
  localparam int SW = $clog2(FFT_N);
  localparam logic [KW-1:0] K_LAST   = '1;
  localparam logic [SW-1:0] S_LAST   = SW'(FFT_N - 1);
  localparam logic [7:0]    GAP_LOAD = 8'(STAGE_GAP - 1);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic [SW-1:0]   s, s_nxt;
  logic [7:0]      gap_cnt, gap_nxt;
  logic            issue, busy_nxt, done_nxt;
  logic [1:0]      ctrl_nxt;
  logic [KW-1:0]   tw_mask, tw_nxt;

  assign oMemAddr = k;
  assign oStage   = s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      k       <= '0;
      s       <= '0;
      gap_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      oact    <= 1'b0;
      octrl   <= 2'b00;
      oTwAddr <= '0;
    end else begin
      state   <= state_nxt;
      k       <= k_nxt;
      s       <= s_nxt;
      gap_cnt <= gap_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      oact    <= issue;
      // operand controls only move on an issue, so they stay frozen through stalls
      if (issue) begin
        octrl   <= ctrl_nxt;
        oTwAddr <= tw_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    s_nxt     = s;
    gap_nxt   = gap_cnt;
    issue     = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          k_nxt     = '0;
          s_nxt     = '0;
          issue     = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      RUN: begin
        busy_nxt = 1'b1;
        // k holds the last issued index; the last one leaves RUN regardless of hold
        if (oact && k == K_LAST) begin
          state_nxt = GAP;
          k_nxt     = '0;
          gap_nxt   = GAP_LOAD;
        end else if (!hold) begin
          issue = 1'b1;
          k_nxt = k + KW'(1);
        end
      end
      GAP: begin
        busy_nxt = 1'b1;
        if (gap_cnt == '0) begin
          if (s == S_LAST) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = RUN;
            s_nxt     = s + SW'(1);
            k_nxt     = '0;
            issue     = 1'b1;
          end
        end else begin
          gap_nxt = gap_cnt - 8'd1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tw_mask  = (KW'(1) << s_nxt) - KW'(1);
    tw_nxt   = (k_nxt & tw_mask) << (SW'(KW) - s_nxt);
    ctrl_nxt = (s_nxt == '0) ? 2'b10 : (k_nxt[0] ? 2'b11 : 2'b00);
  end

endmodule
